// File: rtl/display_pkg.sv
// Shared display constants: BCD digit layout and 7-segment patterns used by
// both the binary-to-BCD converter and the multiplexed display driver.
package display_pkg;

  localparam int NIBBLE_W = 4;
  localparam int DIGITS   = 4;
  localparam int BCD_W    = NIBBLE_W * DIGITS;

  localparam int THOUSANDS = 3;
  localparam int HUNDREDS  = 2;
  localparam int TENS      = 1;
  localparam int UNITS     = 0;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] NUM_0 = 7'b011_1111;
  localparam logic [6:0] NUM_1 = 7'b000_0110;
  localparam logic [6:0] NUM_2 = 7'b101_1011;
  localparam logic [6:0] NUM_3 = 7'b100_1111;
  localparam logic [6:0] NUM_4 = 7'b110_0110;
  localparam logic [6:0] NUM_5 = 7'b110_1101;
  localparam logic [6:0] NUM_6 = 7'b111_1101;
  localparam logic [6:0] NUM_7 = 7'b000_0111;
  localparam logic [6:0] NUM_8 = 7'b111_1111;
  localparam logic [6:0] NUM_9 = 7'b110_1111;

  function automatic logic [6:0] seg_of(input logic [NIBBLE_W-1:0] digit);
    case (digit)
      4'd0:    return NUM_0;
      4'd1:    return NUM_1;
      4'd2:    return NUM_2;
      4'd3:    return NUM_3;
      4'd4:    return NUM_4;
      4'd5:    return NUM_5;
      4'd6:    return NUM_6;
      4'd7:    return NUM_7;
      4'd8:    return NUM_8;
      4'd9:    return NUM_9;
      default: return 7'b000_0000;
    endcase
  endfunction

  // Leading-zero flags; units is never blanked so zero still shows one "0".
  function automatic logic [DIGITS-1:0] blank_flags(input logic [BCD_W-1:0] bcd);
    logic [DIGITS-1:0] b;
    b[THOUSANDS] = (bcd[THOUSANDS*NIBBLE_W +: NIBBLE_W] == '0);
    b[HUNDREDS]  = b[THOUSANDS] && (bcd[HUNDREDS*NIBBLE_W +: NIBBLE_W] == '0);
    b[TENS]      = b[HUNDREDS] && (bcd[TENS*NIBBLE_W +: NIBBLE_W] == '0);
    b[UNITS]     = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import display_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic [NIBBLE_W-1:0] nibble_o
);

  assign nibble_o = (nibble_i >= 4'd5) ? nibble_i + 4'd3 : nibble_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with held outputs,
// leading-zero blank flags and saturation at MAX_VALUE.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int          WIDTH     = 14,
  parameter int unsigned MAX_VALUE = 9999
) (
  input  logic             clk,
  input  logic             user_btn,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BCD_W-1:0] bcd_out,
  output logic [DIGITS-1:0] blank_out,
  output logic             overflow,
  output logic             out_valid
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SAT   = WIDTH'(MAX_VALUE);
  localparam logic [DIGITS-1:0] BLANK_RST = 4'b1110;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WIDTH-1:0]  bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]  bcd_sr_q, bcd_sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_r_q, ovf_r_d;
  logic [BCD_W-1:0]  bcd_out_q, bcd_out_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              overflow_q, overflow_d;
  logic              out_valid_q, out_valid_d;

  logic [BCD_W-1:0]       adj;
  logic [BCD_W+WIDTH-1:0] shift_w;
  logic [BCD_W-1:0]       bcd_shift;
  logic [WIDTH-1:0]       bin_shift;
  logic                   in_above;

  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble_i (bcd_sr_q[d*NIBBLE_W +: NIBBLE_W]),
      .nibble_o (adj[d*NIBBLE_W +: NIBBLE_W])
    );
  end

  assign shift_w   = {adj, bin_sr_q} << 1;
  assign bcd_shift = shift_w[BCD_W+WIDTH-1:WIDTH];
  assign bin_shift = shift_w[WIDTH-1:0];
  assign in_above  = 32'(in_value) > MAX_VALUE;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    bin_sr_d    = bin_sr_q;
    bcd_sr_d    = bcd_sr_q;
    cnt_d       = cnt_q;
    ovf_r_d     = ovf_r_q;
    bcd_out_d   = bcd_out_q;
    blank_d     = blank_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;

    if (state_q == IDLE) begin
      if (in_valid) begin
        bin_sr_d = in_above ? SAT : in_value;
        ovf_r_d  = in_above;
        bcd_sr_d = '0;
        cnt_d    = '0;
        state_d  = SHIFT;
      end
    end else begin
      bcd_sr_d = bcd_shift;
      bin_sr_d = bin_shift;
      cnt_d    = cnt_q + 1'b1;
      // Last shift lands straight in the held outputs; the scratch never shows.
      if (cnt_q == LAST) begin
        bcd_out_d   = bcd_shift;
        blank_d     = blank_flags(bcd_shift);
        overflow_d  = ovf_r_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
    end
  end

  // NOTE: registers update with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge user_btn) begin
    if (!user_btn) begin
      state_q     <= IDLE;
      bin_sr_q    <= '0;
      bcd_sr_q    <= '0;
      cnt_q       <= '0;
      ovf_r_q     <= 1'b0;
      bcd_out_q   <= '0;
      blank_q     <= BLANK_RST;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_sr_q    <= bin_sr_d;
      bcd_sr_q    <= bcd_sr_d;
      cnt_q       <= cnt_d;
      ovf_r_q     <= ovf_r_d;
      bcd_out_q   <= bcd_out_d;
      blank_q     <= blank_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign bcd_out   = bcd_out_q;
  assign blank_out = blank_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner cases plus random values
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  localparam int WIDTH = 14;
  localparam int MAXV  = 9999;
  localparam int LAT   = WIDTH;

  logic             clk = 1'b0;
  logic             user_btn = 1'b0;
  logic [WIDTH-1:0] in_value = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      bcd_out;
  logic [3:0]       blank_out;
  logic             overflow;
  logic             out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] held_bcd;

  bin2bcd_seq #(.WIDTH(WIDTH), .MAX_VALUE(MAXV)) dut (
    .clk       (clk),
    .user_btn  (user_btn),
    .in_value  (in_value),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .blank_out (blank_out),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic logic [15:0] model_bcd(input int v);
    int s;
    s = sat(v);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] model_blank(input int v);
    int s;
    s = sat(v);
    return {s < 1000, s < 100, s < 10, 1'b0};
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    check("wait_ready", in_ready, 1'b1);
  endtask

  // Present one value, then measure latency, busy window and the result.
  task automatic convert(input int v);
    int  k;
    bit  seen;
    bit  busy_ok;
    wait_ready();
    in_value = WIDTH'(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    k       = 0;
    @(negedge clk);
    busy_ok = busy_ok && !in_ready && !out_valid;
    while (k < 40 && !seen) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (out_valid) seen = 1'b1;
      else begin
        busy_ok = busy_ok && !in_ready;
        if (k == 5) check("held_during_conv", bcd_out, held_bcd);
      end
    end
    check("out_valid_seen", seen, 1'b1);
    check("latency", k, LAT);
    check("busy_window", busy_ok, 1'b1);
    check("bcd", bcd_out, model_bcd(v));
    check("blank", blank_out, model_blank(v));
    check("overflow", overflow, v > MAXV);
    @(negedge clk);
    check("pulse_one_cycle", out_valid, 1'b0);
    held_bcd = model_bcd(v);
  endtask

  initial begin
    int vals[3];
    int pulses;
    int last_pulse;
    int low_cnt;
    bit aborted_pulse;

    held_bcd = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_bcd", bcd_out, 16'h0000);
    check("rst_blank", blank_out, 4'b1110);
    user_btn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_bcd", bcd_out, 16'h0000);
    check("idle_blank", blank_out, 4'b1110);
    check("idle_ovf", overflow, 1'b0);
    check("idle_ready", in_ready, 1'b1);
    check("idle_valid", out_valid, 1'b0);

    convert(1234);
    convert(7);
    convert(0);
    convert(9999);
    convert(12000);
    convert(42);
    convert(10000);
    convert(16383);
    convert(1000);
    convert(100);
    convert(10);
    for (int i = 0; i < 20; i++) convert(int'($urandom_range(0, 16383)));
    for (int i = 0; i < 10; i++) convert(int'($urandom_range(0, 9999)));

    // in_valid held high: back-to-back conversions every WIDTH+1 cycles.
    vals = '{5, 50, 500};
    wait_ready();
    in_value   = WIDTH'(vals[0]);
    in_valid   = 1'b1;
    pulses     = 0;
    last_pulse = -1;
    low_cnt    = 0;
    @(posedge clk);
    for (int t = 0; t < 100 && pulses < 3; t++) begin
      @(negedge clk);
      if (out_valid) begin
        check("hold_bcd", bcd_out, model_bcd(vals[pulses]));
        check("hold_blank", blank_out, model_blank(vals[pulses]));
        check("hold_ready_at_pulse", in_ready, 1'b1);
        if (pulses == 0) check("hold_first_lat", t, LAT);
        else begin
          check("hold_spacing", t - last_pulse, LAT + 1);
          check("hold_busy_cycles", low_cnt, LAT);
        end
        last_pulse = t;
        low_cnt    = 0;
        pulses++;
        if (pulses < 3) in_value = WIDTH'(vals[pulses]);
        else in_valid = 1'b0;
      end else if (!in_ready) begin
        low_cnt++;
      end
    end
    check("hold_pulses", pulses, 3);
    held_bcd = model_bcd(500);
    repeat (20) @(negedge clk);
    check("hold_no_extra", bcd_out, held_bcd);

    // Reset mid-conversion aborts with no pulse.
    wait_ready();
    in_value = WIDTH'(4321);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
    user_btn = 1'b0;
    #1;
    check("abort_bcd", bcd_out, 16'h0000);
    check("abort_blank", blank_out, 4'b1110);
    check("abort_ovf", overflow, 1'b0);
    check("abort_valid", out_valid, 1'b0);
    check("abort_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    user_btn = 1'b1;
    aborted_pulse = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) aborted_pulse = 1'b1;
    end
    check("abort_no_pulse", aborted_pulse, 1'b0);
    held_bcd = 16'h0000;
    convert(4321);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential double-dabble converter: binary count in, four BCD digits plus leading-zero blank flags out.
- Sits directly upstream of the 4-digit 7-segment multiplexing driver and feeds its per-digit value inputs.
- The held output registers let the display scan stable digits while a new conversion runs.
- One conversion per WIDTH+1 clocks, valid/ready handshake on the input side.

Parameters:
- WIDTH, 14, binary input width; legal range 4..14.
- MAX_VALUE, 9999, saturation ceiling; inputs above it convert as MAX_VALUE.

Ports:
- clk  input  1  system clock, 24 MHz.
- user_btn  input  1  reset: asynchronous, active-low (0 = reset), single clock domain.
- in_value  input  WIDTH  binary value to convert.
- in_valid  input  1  in_value is valid this cycle.
- in_ready  output  1  converter idle; transfer occurs when in_valid && in_ready at posedge clk.
- bcd_out  output  16  held result: [15:12] thousands (digit1, leftmost) .. [3:0] units (digit4).
- blank_out  output  4  per-digit leading-zero flag, same bit order as bcd_out nibbles; bit 0 (units) always 0.
- overflow  output  1  held; 1 if the last accepted in_value exceeded MAX_VALUE.
- out_valid  output  1  one-cycle pulse when bcd_out/blank_out/overflow update.

Behaviour:
- Reset (user_btn=0, async): state=IDLE, bcd_out=0, blank_out=4'b1110, overflow=0, out_valid=0, shift counter=0, scratch cleared.
- in_ready = (state==IDLE); combinational from state.
- States: IDLE, SHIFT.
- IDLE:
  - On in_valid=1 at edge E0, load bin_sr = min(in_value, MAX_VALUE), ovf_r = (in_value > MAX_VALUE), clear bcd_sr, cnt=0, go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT, each cycle:
  - Every bcd_sr nibble >= 5 gets +3 (4-bit, no carry between nibbles).
  - Then {bcd_sr, bin_sr} shifts left 1; cnt increments.
- Completion at edge E0+WIDTH (cnt reaches WIDTH-1 before the edge):
  - The final shifted bcd_sr is written to bcd_out.
  - blank_out is recomputed.
  - overflow takes ovf_r.
  - out_valid=1 for exactly the following cycle.
  - State returns to IDLE.
- Timing:
  - Latency: out_valid high in the cycle after edge E0+WIDTH (WIDTH=14 gives 14 cycles).
  - in_ready low for WIDTH cycles after acceptance.
  - Earliest next acceptance is edge E0+WIDTH+1.
- Outputs hold their previous values for the whole conversion; no partial results are visible.
- in_valid while busy is ignored, not queued; the upstream block must hold it or re-present it.
- Blanking:
  - blank_out[3] = thousands==0.
  - blank_out[2] = blank_out[3] && hundreds==0.
  - blank_out[1] = blank_out[2] && tens==0.
  - blank_out[0] = 0, so value 0 shows a single "0".
- Saturation: any in_value > MAX_VALUE gives bcd_out=9999 (as BCD) and overflow=1. in_value == MAX_VALUE gives overflow=0.
- Reset mid-conversion aborts immediately. Outputs go to reset values and no out_valid pulse is emitted.
- Simultaneous completion and in_valid: not accepted that cycle, because in_ready is still 0. It is accepted the next cycle if in_valid is still high.

Decomposition:
- Shared package display_pkg:
  - BCD nibble width (4) and digit count (4).
  - Digit index constants (THOUSANDS=3 .. UNITS=0).
  - The 7-segment num_0..num_9 pattern constants, so the driver and this block share one source.
- One natural sub-module: bcd_add3, a combinational per-nibble "if >=5 add 3" cell, instantiated 4 times.

Test Plan:
- Reset then idle: bcd_out=16'h0000, blank_out=4'b1110, overflow=0, in_ready=1, out_valid=0.
- in_value=1234 accepted at edge E0 -> out_valid pulse exactly 14 cycles later, bcd_out=16'h1234, blank_out=4'b0000.
- in_value=7 -> bcd_out=16'h0007, blank_out=4'b1110. in_value=0 -> 16'h0000, blank_out=4'b1110.
- in_value=9999 -> 16'h9999, overflow=0. in_value=12000 -> 16'h9999, overflow=1. A following 42 -> 16'h0042, blank_out=4'b1100, overflow=0.
- in_valid held high continuously with values 5, 50, 500 -> accepts every 15 cycles, out_valid pulses 15 cycles apart, in_ready low for 14 cycles each time.
- user_btn pulled low 6 cycles into converting 4321 -> outputs reset at once, no out_valid. After release, 4321 converts cleanly to 16'h4321.
